// File: rtl/flipflop_pkg.sv
// Shared types and constants for the flip-flop output measurement path.
package flipflop_pkg;

    // Completed-pulse counter width.
    localparam int PULSE_CNT_W = 16;

    // Default width-counter size used by the record type below.
    localparam int DEF_CNT_W = 8;

    // One measurement record: saturation flag above the measured width.
    typedef struct packed {
        logic                 sat;
        logic [DEF_CNT_W-1:0] width;
    } pulse_rec_t;

    // Pulse meter states: waiting for a pulse, or inside one.
    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } meter_state_e;

    // Wrapping increment for the completed-pulse counter.
    function automatic logic [PULSE_CNT_W-1:0] cnt_inc(input logic [PULSE_CNT_W-1:0] c);
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra MSB so that
// full and empty can be told apart when the index bits match.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    // A pop on an empty FIFO is ignored; a push on a full FIFO is only
    // accepted when a pop frees the head slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Head record is presented combinationally; forced to zero when empty
    // so the output is clean out of reset.
    assign rdata = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    // Per-entry write enables for the storage array.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the incoming record into this slot when it is the write target.
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    // Advance read and write pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_pulse_meter.sv
// Measures every high pulse on the flip-flop output, counts completed
// pulses and queues {sat, width} records for a valid/ready consumer.
module out_pulse_meter
    import flipflop_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CNT_W-1:0]       m_width,
    output logic                   m_sat,
    output logic                   overflow,
    output logic [PULSE_CNT_W-1:0] pulse_cnt,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] WIDTH_MAX = '1;

    meter_state_e           state_reg, state_next;
    logic [CNT_W-1:0]       width_reg, width_next;
    logic                   sat_reg, sat_next;
    logic [PULSE_CNT_W-1:0] pulse_cnt_reg;
    logic                   overflow_reg;
    logic                   rec_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W:0]         fifo_rdata;

    // Next-state logic: open a pulse, extend it with saturation, or close it
    // and emit a record on the first low sample.
    always_comb begin
        state_next = state_reg;
        width_next = width_reg;
        sat_next   = sat_reg;
        rec_push   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in) begin
                    state_next = HIGH;
                    width_next = CNT_W'(1);
                    sat_next   = 1'b0;
                end
            end
            HIGH: begin
                if (in) begin
                    if (width_reg == WIDTH_MAX) begin
                        sat_next = 1'b1;
                    end else begin
                        width_next = width_reg + 1'b1;
                    end
                end else begin
                    rec_push   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM and width/saturation registers; reset discards any partial pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            width_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            width_reg <= width_next;
            sat_reg   <= sat_next;
        end
    end

    // Completed-pulse counter and sticky drop flag. A push on a full FIFO is
    // dropped unless the consumer pops the head in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
        end else if (rec_push) begin
            pulse_cnt_reg <= cnt_inc(pulse_cnt_reg);
            if (fifo_full && !m_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (CNT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rec_push),
        .wdata ({sat_reg, width_reg}),
        .pop   (m_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid   = !fifo_empty;
    assign m_sat     = fifo_rdata[CNT_W];
    assign m_width   = fifo_rdata[CNT_W-1:0];
    assign overflow  = overflow_reg;
    assign pulse_cnt = pulse_cnt_reg;
    assign busy      = (state_reg == HIGH);

endmodule

// File: tb/tb_out_pulse_meter.sv
// Directed and randomized checks of out_pulse_meter against a run-length
// reference model with a record queue.
module tb_out_pulse_meter;

    localparam int CNT_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int WMAX       = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_s;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] m_width;
    logic             m_sat;
    logic             overflow;
    logic [15:0]      pulse_cnt;
    logic             busy;

    out_pulse_meter #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_s),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_width   (m_width),
        .m_sat     (m_sat),
        .overflow  (overflow),
        .pulse_cnt (pulse_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int w;
        bit s;
    } rec_t;

    // Reference model state
    rec_t q[$];
    int   run_len;
    int   cnt_model;
    bit   ovf_model;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of one rising edge, working from the run length of 1s on the input.
    task automatic model_edge(input bit i, input bit r, input bit s);
        rec_t rec;
        if (s) begin
            q.delete();
            run_len   = 0;
            cnt_model = 0;
            ovf_model = 0;
            return;
        end
        if (q.size() > 0 && r) begin
            $display("pop  width=%0d sat=%0d pulse_cnt=%0d", q[0].w, q[0].s, cnt_model);
            void'(q.pop_front());
        end
        if (run_len > 0 && !i) begin
            rec.w = (run_len > WMAX) ? WMAX : run_len;
            rec.s = (run_len > WMAX);
            if (q.size() < FIFO_DEPTH) q.push_back(rec);
            else ovf_model = 1;
            cnt_model = (cnt_model + 1) % 65536;
            run_len   = 0;
        end else if (i) begin
            run_len++;
        end
    endtask

    task automatic check_all();
        chk("m_valid", m_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("m_width", m_width, q[0].w);
            chk("m_sat", m_sat, q[0].s);
        end
        chk("busy", busy, run_len > 0);
        chk("overflow", overflow, ovf_model);
        chk("pulse_cnt", pulse_cnt, cnt_model);
    endtask

    // One clock: drive inputs, take the edge, update the model, then compare.
    task automatic step(input bit i, input bit r, input bit s);
        in_s    = i;
        m_ready = r;
        rst     = s;
        @(posedge clk);
        model_edge(i, r, s);
        #1;
        check_all();
    endtask

    task automatic pulse(input int hi, input int lo, input bit r);
        for (int k = 0; k < hi; k++) step(1'b1, r, 1'b0);
        for (int k = 0; k < lo; k++) step(1'b0, r, 1'b0);
    endtask

    initial begin
        q.delete();
        run_len   = 0;
        cnt_model = 0;
        ovf_model = 0;
        in_s      = 1'b0;
        m_ready   = 1'b0;
        rst       = 1'b1;

        // Reset, then idle input
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);
        chk("idle_valid", m_valid, 1'b0);
        chk("idle_cnt", pulse_cnt, 16'd0);

        // Pulses of 1, 3, 7 cycles with the consumer ready
        pulse(1, 2, 1'b1);
        pulse(3, 2, 1'b1);
        pulse(7, 3, 1'b1);
        chk("three_pulses_cnt", pulse_cnt, 16'd3);

        // Saturation: 300 cycles, exactly 255, one past the limit
        pulse(300, 1, 1'b0);
        chk("sat300_width", m_width, 8'd255);
        chk("sat300_sat", m_sat, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        pulse(255, 1, 1'b0);
        chk("w255_width", m_width, 8'd255);
        chk("w255_sat", m_sat, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        pulse(256, 2, 1'b1);

        // Overflow: six 2-cycle pulses with 1-cycle gaps, consumer stalled
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) pulse(2, 1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_cnt", pulse_cnt, 16'd6);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0);
        chk("ovf_drained", m_valid, 1'b0);

        // Full FIFO with a push and pop on the same edge
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < FIFO_DEPTH; k++) pulse(k + 1, 1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("full_pushpop_ovf", overflow, 1'b0);
        chk("full_pushpop_head", m_width, 8'd2);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0);
        chk("full_pushpop_cnt", pulse_cnt, 16'd5);

        // Reset in the middle of a pulse; the input stays high afterwards
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        pulse(4, 0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        pulse(3, 1, 1'b0);
        chk("rst_mid_cnt", pulse_cnt, 16'd1);
        chk("rst_mid_width", m_width, 8'd3);
        step(1'b0, 1'b1, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 40), 1'b0);
        end
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/out_pulse_meter.md
# out_pulse_meter

Downstream consumer of the `flipflop` stage's `out` signal. It measures every high pulse on `out` in clock cycles and counts completed pulses. Each measurement is buffered in a small show-ahead FIFO and handed to the next stage over a valid/ready interface. This gives the bench and any downstream logic a cycle-accurate record of the flip-flop's output behaviour.

## Interface
- `CNT_W`, 8: width counter bits; widths saturate at 2^CNT_W-1.
- `FIFO_DEPTH`, 4: record buffer entries, power of two, ≥2.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- `in`  in  1  pulse input, driven by `flipflop.out`; same clock domain, already registered, so no synchronizer.
- `m_valid`  out  1  head FIFO record available.
- `m_ready`  in  1  consumer accepts head record.
- `m_width`  out  CNT_W  high-time of head record, in cycles.
- `m_sat`  out  1  head record's true width exceeded 2^CNT_W-1.
- `overflow`  out  1  sticky: ≥1 record dropped because the FIFO was full.
- `pulse_cnt`  out  16  completed pulses since reset, wraps at 2^16.
- `busy`  out  1  a pulse is in progress (FSM in HIGH).

## Operation
- FSM, 2 states:
  - IDLE: if `in`=1, go to HIGH, width←1, sat←0.
  - HIGH: if `in`=1, width←width+1, saturating at 2^CNT_W-1; sat←1 if already at max. If `in`=0, push {width, sat}, pulse_cnt←pulse_cnt+1, go to IDLE.
- Width is the number of rising edges at which `in` was sampled 1. A 1-cycle pulse gives width 1. Width 0 is never emitted.
- Push on full FIFO: record dropped, `overflow`←1, `pulse_cnt` still increments.
- Push and pop in the same cycle:
  - When full, the pop frees a slot and the push is accepted; no overflow.
  - When empty, the push lands and `m_valid` rises next cycle.
- Pop happens on a rising edge where `m_valid`&&`m_ready`. `m_ready` while `m_valid`=0 is ignored.
- `m_width` and `m_sat` are don't-care while `m_valid`=0. The bench must not check them then.
- `overflow` clears only on `rst`.
- Back-to-back pulses (`in` low for exactly one cycle) are measured separately, with no loss.

## Timing
- Reset values: `m_valid`=0, `m_width`=0, `m_sat`=0, `overflow`=0, `pulse_cnt`=0, `busy`=0; FSM=IDLE; FIFO empty.
- `rst` overrides everything, including mid-pulse: the partial pulse is discarded and not counted.
- If `in` is still 1 on the first edge after `rst` deasserts, a new pulse starts with width 1. This truncated pulse is measured.
- Latency:
  - Record is written at edge E, the first edge sampling `in`=0 after a pulse.
  - `m_valid` is 1 in the cycle after E when the FIFO was empty.
  - `pulse_cnt` updates at E.
- `busy` rises at the edge that first samples `in`=1 and falls at E.
- Consumer may hold `m_ready` low indefinitely. The head record stays stable until popped.

## Structure
- Shared package `flipflop_pkg`:
  - typedef `pulse_rec_t` = {sat, width[CNT_W-1:0]};
  - FSM state enum `meter_state_e` {IDLE, HIGH};
  - constant `PULSE_CNT_W`=16.
- Sub-module `sync_fifo`:
  - parameterized width/depth, show-ahead;
  - ports push/pop/full/empty;
  - pointer wrap with an extra MSB for full/empty discrimination.
- Top contains FSM, width counter, pulse counter, overflow logic.

## Test plan
- Reset, `in`=0 for 10 cycles → all outputs at reset values, `m_valid`=0.
- `in` high 1 cycle, then 3 cycles, then 7 cycles, `m_ready`=1 → records width 1, 3, 7, each `m_sat`=0; `pulse_cnt`=3.
- `CNT_W`=8, `in` high 300 cycles → width 255, `m_sat`=1. `in` high exactly 255 cycles → width 255, `m_sat`=0.
- `m_ready`=0, six 2-cycle pulses with 1-cycle gaps, `FIFO_DEPTH`=4 → 4 records held, `overflow`=1, `pulse_cnt`=6. Then `m_ready`=1 → 4 records of width 2, then `m_valid`=0.
- FIFO full, push and pop in the same cycle → no overflow, occupancy stays 4, order preserved.
- Assert `rst` during a 10-cycle pulse at cycle 5 with `in` held high 3 more cycles → no record for the aborted pulse; one record of width 3 after release; `pulse_cnt`=1.
